// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer in front of the single-port data RAM.
// Port 0 = core load/store, port 1 = program loader / debug master.
// Each transaction runs IDLE -> ADDR -> DATA -> DONE, one cycle per state.
// Optional feature: define DMEM_ARB_RR_EN for round-robin tie breaking;
// without it a tie always goes to port 0. The port-1 burst lock works in both.
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_lock,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0] state;
  logic       owner;     // port that owns the current transaction
  logic       last_gnt;  // port granted most recently
  logic       cur_we;    // ram_we is cleared after ADDR, so remember the direction here
  logic       win;       // arbitration result, only meaningful in IDLE

  // Pick the winner: lock first, then a lone requester, then the tie policy.
  always_comb begin
    win = 1'b0;
    if (last_gnt && m1_lock && m1_req) begin
      win = 1'b1;
    end else if (m0_req && !m1_req) begin
      win = 1'b0;
    end else if (m1_req && !m0_req) begin
      win = 1'b1;
    end else begin
`ifdef DMEM_ARB_RR_EN
      // last_gnt resets to 1, so the first tie after reset goes to port 0.
      win = ~last_gnt;
`else
      win = 1'b0;
`endif
    end
  end

  // Sequencer: latch the winner's access, pulse ram_we for one cycle,
  // capture read data and issue a one-cycle ack to the owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      owner    <= 1'b0;
      last_gnt <= 1'b1;
      cur_we   <= 1'b0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (m0_req || m1_req) begin
            owner    <= win;
            last_gnt <= win;
            cur_we   <= win ? m1_we : m0_we;
            ram_we   <= win ? m1_we : m0_we;
            ram_addr <= win ? m1_addr : m0_addr;
            ram_din  <= win ? m1_wdata : m0_wdata;
            state    <= S_ADDR;
          end
        end
        S_ADDR: begin
          ram_we <= 1'b0;
          state  <= S_DATA;
        end
        S_DATA: begin
          // RAM output is valid now (one cycle after the address was presented).
          if (!cur_we) begin
            if (owner) m1_rdata <= ram_dout;
            else       m0_rdata <= ram_dout;
          end
          if (owner) m1_ack <= 1'b1;
          else       m0_ack <= 1'b1;
          state <= S_DONE;
        end
        default: begin
          // DONE: requests are ignored here; a held req is seen next IDLE.
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural RAM and a
// transaction-level reference model of the arbitration rules.
module tb_dmem_arbiter;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        lock;
    int          gap;
  } item_t;

  typedef struct {
    int          port;
    int          cyc;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0]       req = '0;
  logic [1:0]       we = '0;
  logic [1:0][31:0] addr = '0;
  logic [1:0][31:0] wdata = '0;
  logic             lock = 1'b0;
  logic             m0_ack, m1_ack, ram_we;
  logic [31:0]      m0_rdata, m1_rdata, ram_addr, ram_din;
  logic [31:0]      ram_dout = '0;
  logic [1:0]       ack;
  logic [1:0][31:0] rd;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  item_t dq0[$];
  item_t dq1[$];
  exp_t  expq[$];
  logic [1:0] dbusy = '0;

  // reference model state
  logic [31:0] ram  [0:255];
  logic [31:0] mmem [0:255];
  logic [1:0][31:0] m_rd = '0;
  logic        m_last = 1'b1;
  int          free_cyc = 0;
  logic        pw_v = 1'b0;
  logic [7:0]  pw_a = '0;
  logic [31:0] pw_d = '0;
  int          pw_cyc = -1;
  int          we_cyc = -1;
  int          addr_cyc = -1;
  logic [31:0] exp_addr = '0;
  logic [31:0] exp_din = '0;
  logic        exp_wr = 1'b0;

  assign ack = {m1_ack, m0_ack};
  assign rd  = {m1_rdata, m0_rdata};

  dmem_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
    .m1_lock(lock), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // synchronous single-port RAM, read-before-write
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr[9:2]] <= ram_din;
    ram_dout <= ram[ram_addr[9:2]];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  task automatic push(input int p, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic lk, input int gap);
    item_t it;
    it.we = w; it.addr = a; it.wdata = d; it.lock = lk; it.gap = gap;
    if (p == 0) dq0.push_back(it);
    else        dq1.push_back(it);
  endtask

  task automatic load(input int p, input item_t it);
    we[p] = it.we; addr[p] = it.addr; wdata[p] = it.wdata;
    if (p == 1) lock = it.lock;
    req[p] = 1'b1;
  endtask

  // Requester: holds req until ack; chains the next item with gap 0 by keeping req high.
  task automatic run_drv(input int p);
    item_t it;
    int    wt;
    bit    more;
    forever begin
      @(negedge clk);
      if ((p == 0 ? dq0.size() : dq1.size()) == 0) continue;
      it = (p == 0) ? dq0.pop_front() : dq1.pop_front();
      dbusy[p] = 1'b1;
      repeat (it.gap) @(negedge clk);
      load(p, it);
      more = 1;
      while (more) begin
        wt = 0;
        do begin @(negedge clk); wt++; end while (!ack[p] && !rst && wt < 300);
        if (rst) begin
          req[p] = 1'b0; more = 0;
        end else if (!ack[p]) begin
          checks++; fails++;
          $display("FAIL ack_timeout port %0d: got no ack want ack within 300 cycles", p);
          req[p] = 1'b0; more = 0;
        end else if ((p == 0 ? dq0.size() : dq1.size()) > 0 &&
                     (p == 0 ? dq0[0].gap : dq1[0].gap) == 0) begin
          it = (p == 0) ? dq0.pop_front() : dq1.pop_front();
          load(p, it);
        end else begin
          req[p] = 1'b0; more = 0;
        end
      end
      dbusy[p] = 1'b0;
    end
  endtask

  initial run_drv(0);
  initial run_drv(1);

  // Reference model: one transaction per 4-cycle slot, winner chosen by the
  // arbitration rules whenever the bus is free and someone is requesting.
  initial forever begin
    int   w;
    exp_t e;
    @(posedge clk or posedge rst);
    if (rst) begin
      expq.delete();
      m_last = 1'b1; m_rd = '0; free_cyc = 0; pw_v = 1'b0;
      we_cyc = -1; addr_cyc = -1;
      continue;
    end
    if (pw_v && cyc == pw_cyc) begin mmem[pw_a] = pw_d; pw_v = 1'b0; end
    if (cyc >= free_cyc && req != 2'b00) begin
      if (m_last && lock && req[1])      w = 1;
      else if (req == 2'b01)             w = 0;
      else if (req == 2'b10)             w = 1;
      else begin
`ifdef DMEM_ARB_RR_EN
        w = m_last ? 0 : 1;
`else
        w = 0;
`endif
      end
      m_last = w[0];
      e.port = w; e.cyc = cyc + 3;
      if (we[w]) begin
        pw_v = 1'b1; pw_a = addr[w][9:2]; pw_d = wdata[w]; pw_cyc = cyc + 1;
        we_cyc = cyc + 1;
      end else begin
        m_rd[w] = mmem[addr[w][9:2]];
      end
      e.rdata = m_rd[w];
      addr_cyc = cyc + 1; exp_addr = addr[w]; exp_wr = we[w]; exp_din = wdata[w];
      expq.push_back(e);
      free_cyc = cyc + 4;
    end
  end

  // Monitor: compare every ack and RAM-side strobe against the model.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst) continue;
    if (m0_ack && m1_ack) begin
      checks++; fails++;
      $display("FAIL dual_ack @cycle %0d: got both acks want at most one", cyc);
    end
    if (m0_ack || m1_ack) begin
      if (expq.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_ack @cycle %0d: got ack=%b want none", cyc, ack);
      end else begin
        e = expq.pop_front();
        chk("ack_port", {31'd0, m1_ack}, e.port);
        chk("ack_cycle", cyc, e.cyc);
        chk("rdata", rd[e.port], e.rdata);
      end
    end else if (expq.size() > 0 && expq[0].cyc < cyc) begin
      e = expq.pop_front();
      checks++; fails++;
      $display("FAIL missing_ack port %0d: got none want ack at cycle %0d", e.port, e.cyc);
    end
    if (ram_we || cyc == we_cyc) chk("ram_we", {31'd0, ram_we}, {31'd0, cyc == we_cyc});
    if (cyc == addr_cyc) begin
      chk("ram_addr", ram_addr, exp_addr);
      if (exp_wr) chk("ram_din", ram_din, exp_din);
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((dq0.size() || dq1.size() || dbusy != 0 || req != 0 || expq.size()) && n < 5000) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n >= 5000) begin
      fails++;
      $display("FAIL drain_timeout: got pending work after %0d cycles want idle", n);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_m0_ack"}, {31'd0, m0_ack}, 0);
    chk({tag, "_m1_ack"}, {31'd0, m1_ack}, 0);
    chk({tag, "_m0_rdata"}, m0_rdata, 0);
    chk({tag, "_m1_rdata"}, m1_rdata, 0);
    chk({tag, "_ram_we"}, {31'd0, ram_we}, 0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_ram_din"}, ram_din, 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) begin ram[i] = '0; mmem[i] = '0; end
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // both ports held for 4 transactions each (first tie after reset)
    for (int i = 0; i < 4; i++) begin
      push(0, 1'b1, 32'h100 + 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b0, 0);
      push(1, 1'b0, 32'h100 + 32'(i * 4), 32'h0, 1'b0, 0);
    end
    wait_idle();

    // single read on an idle bus
    push(0, 1'b0, 32'h10, 32'h0, 1'b0, 0);
    wait_idle();

    // m1 writes, m0 reads it back
    push(1, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0, 0);
    wait_idle();
    push(0, 1'b0, 32'h40, 32'h0, 1'b0, 0);
    wait_idle();

    // locked m1 burst while m0 waits
    for (int i = 0; i < 3; i++)
      push(1, 1'b1, 32'(i * 4), 32'h5500_0000 + 32'(i), 1'b1, 0);
    push(1, 1'b0, 32'h40, 32'h0, 1'b0, 0);
    repeat (2) @(negedge clk);
    push(0, 1'b0, 32'h0, 32'h0, 1'b0, 0);
    wait_idle();

    // reset during the ADDR cycle of an m0 write
    push(0, 1'b1, 32'h80, 32'h12345678, 1'b0, 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!ram_we && n < 50);
    chk("abort_saw_write_pulse", {31'd0, ram_we}, 1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("abort");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_idle();
    push(0, 1'b0, 32'h80, 32'h0, 1'b0, 0);
    wait_idle();

    // randomized traffic on both ports
    for (int i = 0; i < 40; i++) begin
      push(0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)) << 2, $urandom,
           1'b0, int'($urandom_range(0, 3)));
      push(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)) << 2, $urandom,
           $urandom_range(0, 3) == 0, int'($urandom_range(0, 3)));
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
